// File: rtl/instruction_decoder.sv
// RV32I decode-stage field slicer, format classifier and sticky illegal-opcode flag.
// Define INSTR_DECODER_IMM_EN to generate the sign-extended immediate on imm_o.
module instruction_decoder (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instruction_word_i,
  input  logic        valid_i,
  input  logic        clr_i,
  output logic [6:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic [2:0]  funct3_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [6:0]  funct7_o,
  output logic [2:0]  format_o,
  output logic [31:0] imm_o,
  output logic        illegal_o,
  output logic        illegal_seen_o
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  logic [31:0] inst;
  logic [2:0]  fmt;

  assign inst     = instruction_word_i;
  assign opcode_o = inst[6:0];
  assign rd_o     = inst[11:7];
  assign funct3_o = inst[14:12];
  assign rs1_o    = inst[19:15];
  assign rs2_o    = inst[24:20];
  assign funct7_o = inst[31:25];

  // Full 7-bit match, so any opcode with bits [1:0] != 2'b11 falls to unknown.
  always_comb begin
    fmt = FMT_X;
    case (inst[6:0])
      7'b0110011: fmt = FMT_R;
      7'b0010011,
      7'b0000011,
      7'b1100111,
      7'b1110011,
      7'b0001111: fmt = FMT_I;
      7'b0100011: fmt = FMT_S;
      7'b1100011: fmt = FMT_B;
      7'b0110111,
      7'b0010111: fmt = FMT_U;
      7'b1101111: fmt = FMT_J;
      default:    fmt = FMT_X;
    endcase
  end

  assign format_o  = fmt;
  assign illegal_o = (fmt == FMT_X);

`ifdef INSTR_DECODER_IMM_EN
  logic [31:0] imm;

  always_comb begin
    imm = 32'h0;
    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'h000};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

  assign imm_o = imm;
`else
  assign imm_o = 32'h0;
`endif

  // Clear wins over capture so software can acknowledge in the same cycle a new fault arrives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_seen_o <= 1'b0;
    end else if (clr_i) begin
      illegal_seen_o <= 1'b0;
    end else if (valid_i && illegal_o) begin
      illegal_seen_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: decode vector table via a scoreboard queue,
// plus hand-written sticky-flag and reset sequences.
module tb_instruction_decoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] word;
  logic        valid;
  logic        clr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [2:0]  fmt;
  logic [31:0] imm;
  logic        illegal;
  logic        illegal_seen;

  int checks = 0;
  int failures = 0;

  instruction_decoder dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .instruction_word_i (word),
    .valid_i            (valid),
    .clr_i              (clr),
    .opcode_o           (opcode),
    .rd_o               (rd),
    .funct3_o           (funct3),
    .rs1_o              (rs1),
    .rs2_o              (rs2),
    .funct7_o           (funct7),
    .format_o           (fmt),
    .imm_o              (imm),
    .illegal_o          (illegal),
    .illegal_seen_o     (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] w, input logic [6:0] op, input logic [4:0] d,
                              input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [6:0] f7, input logic [2:0] fm, input logic il,
                              input logic [31:0] im);
    vec_t v;
    v.word = w; v.opcode = op; v.rd = d; v.funct3 = f3; v.rs1 = s1; v.rs2 = s2;
    v.funct7 = f7; v.fmt = fm; v.ill = il;
`ifdef INSTR_DECODER_IMM_EN
    v.imm = im;
`else
    v.imm = (im == im) ? 32'h0 : 32'h0;
`endif
    return v;
  endfunction

  initial begin
    vec_t e;
    vec_t v;
    // word, opcode, rd, f3, rs1, rs2, f7, format, illegal, imm (when enabled)
    vecs.push_back(mk(32'h002081B3, 7'h33, 5'h03, 3'd0, 5'h01, 5'h02, 7'h00, 3'd0, 1'b0, 32'h00000000)); // ADD
    vecs.push_back(mk(32'h00A52283, 7'h03, 5'h05, 3'd2, 5'h0A, 5'h0A, 7'h00, 3'd1, 1'b0, 32'h0000000A)); // LW
    vecs.push_back(mk(32'h0020A223, 7'h23, 5'h04, 3'd2, 5'h01, 5'h02, 7'h00, 3'd2, 1'b0, 32'h00000004)); // SW
    vecs.push_back(mk(32'h12345537, 7'h37, 5'h0A, 3'd5, 5'h08, 5'h03, 7'h09, 3'd4, 1'b0, 32'h12345000)); // LUI
    vecs.push_back(mk(32'hFFF00093, 7'h13, 5'h01, 3'd0, 5'h00, 5'h1F, 7'h7F, 3'd1, 1'b0, 32'hFFFFFFFF)); // ADDI -1
    vecs.push_back(mk(32'hFE208EE3, 7'h63, 5'h1D, 3'd0, 5'h01, 5'h02, 7'h7F, 3'd3, 1'b0, 32'hFFFFFFFC)); // BEQ -4
    vecs.push_back(mk(32'h008000EF, 7'h6F, 5'h01, 3'd0, 5'h00, 5'h08, 7'h00, 3'd5, 1'b0, 32'h00000008)); // JAL +8
    vecs.push_back(mk(32'hFFFFF517, 7'h17, 5'h0A, 3'd7, 5'h1F, 5'h1F, 7'h7F, 3'd4, 1'b0, 32'hFFFFF000)); // AUIPC
    vecs.push_back(mk(32'h00000073, 7'h73, 5'h00, 3'd0, 5'h00, 5'h00, 7'h00, 3'd1, 1'b0, 32'h00000000)); // ECALL
    vecs.push_back(mk(32'h0000000F, 7'h0F, 5'h00, 3'd0, 5'h00, 5'h00, 7'h00, 3'd1, 1'b0, 32'h00000000)); // FENCE
    vecs.push_back(mk(32'h00000000, 7'h00, 5'h00, 3'd0, 5'h00, 5'h00, 7'h00, 3'd7, 1'b1, 32'h00000000)); // all-zero
    vecs.push_back(mk(32'h00000032, 7'h32, 5'h00, 3'd0, 5'h00, 5'h00, 7'h00, 3'd7, 1'b1, 32'h00000000)); // bits[1:0]=10
    vecs.push_back(mk(32'h0000007F, 7'h7F, 5'h00, 3'd0, 5'h00, 5'h00, 7'h00, 3'd7, 1'b1, 32'h00000000)); // unused opcode

    rst_n = 1'b0;
    valid = 1'b0;
    clr   = 1'b0;
    word  = 32'h0;
    #12;
    cmp("reset_seen", {31'h0, illegal_seen}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode table: expected record is queued as the word is driven, popped once outputs settle.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      word = vecs[i].word;
      sb.push_back(vecs[i]);
      #1;
      if (sb.size() == 0) begin
        cmp("scoreboard_empty", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        cmp("opcode", {25'h0, opcode}, {25'h0, e.opcode});
        cmp("rd",     {27'h0, rd},     {27'h0, e.rd});
        cmp("funct3", {29'h0, funct3}, {29'h0, e.funct3});
        cmp("rs1",    {27'h0, rs1},    {27'h0, e.rs1});
        cmp("rs2",    {27'h0, rs2},    {27'h0, e.rs2});
        cmp("funct7", {25'h0, funct7}, {25'h0, e.funct7});
        cmp("format", {29'h0, fmt},    {29'h0, e.fmt});
        cmp("illegal", {31'h0, illegal}, {31'h0, e.ill});
        cmp("imm",    imm,             e.imm);
      end
    end
    // Invalid illegal instructions must not arm the flag across edges.
    cmp("seen_after_table", {31'h0, illegal_seen}, 32'h0);

    // Sticky flag: illegal word with valid low leaves the flag clear.
    @(negedge clk);
    word = 32'h00000000;
    valid = 1'b0;
    @(posedge clk); #1;
    cmp("ill_novalid", {31'h0, illegal}, 32'h1);
    cmp("seen_novalid", {31'h0, illegal_seen}, 32'h0);

    @(negedge clk);
    valid = 1'b1;
    @(posedge clk); #1;
    cmp("seen_set", {31'h0, illegal_seen}, 32'h1);

    // Legal valid instruction holds the flag.
    @(negedge clk);
    word = 32'h002081B3;
    @(posedge clk); #1;
    cmp("seen_hold", {31'h0, illegal_seen}, 32'h1);

    // Clear has priority over a simultaneous valid illegal capture.
    @(negedge clk);
    word = 32'h00000000;
    clr = 1'b1;
    @(posedge clk); #1;
    cmp("seen_clr_priority", {31'h0, illegal_seen}, 32'h0);

    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;
    cmp("seen_reset_again", {31'h0, illegal_seen}, 32'h1);

    // Asynchronous reset between edges clears the flag; slices keep tracking.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("seen_async_rst", {31'h0, illegal_seen}, 32'h0);
    word = 32'h12345537;
    #1;
    cmp("opcode_in_rst", {25'h0, opcode}, 32'h37);
    cmp("format_in_rst", {29'h0, fmt}, 32'h4);
    @(posedge clk); #1;
    cmp("seen_held_in_rst", {31'h0, illegal_seen}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b0;

    // Random words against an independent bit-slice reference.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      v.word = $urandom;
      v.opcode = v.word[6:0];
      v.rd = v.word[11:7];
      v.rs1 = v.word[19:15];
      v.rs2 = v.word[24:20];
      word = v.word;
      sb.push_back(v);
      #1;
      e = sb.pop_front();
      cmp("rnd_fields", {opcode, rd, rs1, rs2}, {e.opcode, e.rd, e.rs1, e.rs2});
      cmp("rnd_ill_vs_fmt", {31'h0, illegal}, {31'h0, (fmt == 3'd7)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000 required");
    $fatal(1);
  end

endmodule

// File: doc/instruction_decoder.md
Name: instruction_decoder

Overview:
- RV32I instruction field decoder in the decode stage of the core.
- Slices a 32-bit instruction word into its standard fields, classifies the instruction format and flags illegal opcodes.
- All field outputs are purely combinational (zero latency). The only state is a sticky illegal-instruction flag for debug/trap logic.
- Optionally generates the sign-extended immediate.

Parameters:
- None. Widths are fixed by RV32I.

Ports:
- clk_i  input  1  system clock; rising edge; used only by the sticky flag.
- rst_ni  input  1  reset; asynchronous, active-low.
- instruction_word_i  input  32  raw instruction word.
- valid_i  input  1  instruction_word_i holds a real instruction this cycle; qualifies sticky-flag capture only.
- clr_i  input  1  synchronous clear of illegal_seen_o.
- opcode_o  output  7  bits [6:0].
- rd_o  output  5  bits [11:7]; sliced for every format (S/B carry imm low bits here).
- funct3_o  output  3  bits [14:12].
- rs1_o  output  5  bits [19:15]; sliced for every format.
- rs2_o  output  5  bits [24:20].
- funct7_o  output  7  bits [31:25].
- format_o  output  3  format class: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=unknown.
- imm_o  output  32  sign-extended immediate (see Optional Feature).
- illegal_o  output  1  current opcode is not a supported RV32I opcode.
- illegal_seen_o  output  1  sticky record of any valid illegal instruction.

Behaviour:
- Field slicing:
  - Unconditional bit slices, independent of opcode, valid_i, clock and reset.
  - Settle within the same delta/combinational path as instruction_word_i.
- Format classification by opcode:
  - 0110011 gives R.
  - 0010011, 0000011, 1100111, 1110011, 0001111 give I.
  - 0100011 gives S.
  - 1100011 gives B.
  - 0110111, 0010111 give U.
  - 1101111 gives J.
  - Any other opcode gives 7.
- illegal_o = 1 exactly when format_o = 7. This includes every opcode with bits [1:0] != 2'b11.
- Sticky flag:
  - illegal_seen_o resets to 0 asynchronously when rst_ni is low.
  - On a rising edge with rst_ni high:
    - clr_i = 1 gives 0 (clr_i has priority over capture).
    - else valid_i & illegal_o gives 1.
    - else hold.
- Reset mid-operation:
  - Affects only illegal_seen_o.
  - All combinational outputs keep tracking instruction_word_i during reset.
- X on instruction_word_i propagates to the slices. No X-masking is required.

Optional Feature:
- Macro: INSTR_DECODER_IMM_EN.
- Defined: imm_o carries the sign-extended immediate, with bit 31 as the sign:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R and unknown: 0.
- Not defined: imm_o is tied to 32'h0. All other behaviour is unchanged.

Test Plan:
- 0x002081B3 (ADD x3,x1,x2) -> opcode 0x33, rd 0x03, rs1 0x01, rs2 0x02, funct3 0, funct7 0, format 0, illegal_o 0, imm 0.
- 0x00A52283 (LW x5,10(x10)) -> opcode 0x03, rd 0x05, rs1 0x0A, funct3 2, format 1, imm 0x0000000A.
- 0x0020A223 (SW x2,4(x1)) -> opcode 0x23, rd 0x04, rs1 0x01, rs2 0x02, funct3 2, format 2, imm 0x00000004.
- 0x12345537 (LUI x10,0x12345) -> opcode 0x37, rd 0x0A, rs1 0x08, format 4, imm 0x12345000.
- 0xFFF00093 (ADDI x1,x0,-1) -> format 1, imm 0xFFFFFFFF (IMM_EN defined); imm 0 when undefined.
- Sticky flag sequence:
  - 0x00000000 with valid_i=0 -> illegal_o 1, illegal_seen_o stays 0.
  - Set valid_i=1, apply a clock edge -> illegal_seen_o 1.
  - Apply clr_i=1 on the next edge -> 0.
  - Set the flag again, then assert rst_ni low with no clock edge -> 0 immediately.
